truth_table_sweeper: RTL and testbench

//  Recovers the minterm list of a combinational or pipelined N-input boolean function by driving

---
 rtl/truth_table_sweeper.sv | 192 +++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// Module: truth_table_sweeper
//
// Purpose:
//   Recovers the minterm list and full truth table of an N-input boolean
//   function implemented in hardware. The sweeper drives every input vector
//   0 .. 2^N_VARS-1 in ascending order on x_out. It waits FN_LATENCY cycles
//   for the function output to settle, then samples f_in. Every vector for
//   which the function is 1 is streamed out as a minterm over a valid/ready
//   interface. The sampled truth table and the running minterm count are
//   also exposed.
//
// Parameters:
//   N_VARS      number of function inputs; the sweep covers 2^N_VARS vectors
//   FN_LATENCY  cycles between an x_out change and a valid f_in
//               (0 = purely combinational function)
//
// Ports:
//   clk           in   1            sole clock, rising edge
//   rst           in   1            synchronous, active-high reset
//   start         in   1            begins a sweep (only honoured in IDLE)
//   busy          out  1            high while the sweep is in progress
//   done          out  1            one-cycle pulse when the sweep completes
//   x_out         out  N_VARS       vector driven to the function under test
//   f_in          in   1            function output for x_out
//   m_valid       out  1            minterm available
//   m_ready       in   1            consumer accepts the minterm
//   m_index       out  N_VARS       index of the presented minterm
//   minterm_count out  N_VARS+1     minterms found so far; final when done=1
//   truth_table   out  2^N_VARS     bit i = sampled function value for vector i
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_VARS     = 5,
    parameter int FN_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [N_VARS-1:0]      x_out,
    input  logic                   f_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_VARS-1:0]      m_index,
    output logic [N_VARS:0]        minterm_count,
    output logic [(1<<N_VARS)-1:0] truth_table
);

    // The latency counter is at least one bit wide. This keeps the
    // combinational case (FN_LATENCY = 0) free of zero-width vectors.
    localparam int CNT_W = (FN_LATENCY > 0) ? $clog2(FN_LATENCY + 1) : 1;

    localparam logic [CNT_W-1:0]  LAT_RELOAD = CNT_W'(FN_LATENCY);
    localparam logic [N_VARS-1:0] LAST_VEC   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;

    // f_in is only trusted once the latency counter has run down to zero.
    logic sample_now;
    logic last_vec;
    logic handshake;

    assign sample_now = (state == WAIT) && (wait_cnt == '0);
    assign last_vec   = (x_out == LAST_VEC);
    assign handshake  = (state == EMIT) && m_ready;

    // State register. A reset in any state, including mid-EMIT, returns the
    // FSM to IDLE. Any minterm still on offer is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The sweep never wraps: vector 2^N_VARS-1 is always
    // the last one, whether it ends through WAIT (f=0) or through EMIT (f=1).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (sample_now) begin
                    if (f_in) begin
                        next_state = EMIT;
                    end else if (last_vec) begin
                        next_state = DONE;
                    end
                end
            end
            EMIT: begin
                if (m_ready) begin
                    next_state = last_vec ? DONE : WAIT;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // Starting a sweep clears the previous result. The result is otherwise
    // left untouched after DONE, so the host can read it at leisure.
    // The minterm index and count are captured on the same edge that samples
    // f_in. They are therefore already stable in the first EMIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out         <= '0;
            wait_cnt      <= '0;
            m_index       <= '0;
            minterm_count <= '0;
            truth_table   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_out         <= '0;
                        wait_cnt      <= LAT_RELOAD;
                        minterm_count <= '0;
                        truth_table   <= '0;
                    end
                end
                WAIT: begin
                    if (!sample_now) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        truth_table[x_out] <= f_in;
                        if (f_in) begin
                            m_index       <= x_out;
                            minterm_count <= minterm_count + 1'b1;
                        end else if (!last_vec) begin
                            x_out    <= x_out + 1'b1;
                            wait_cnt <= LAT_RELOAD;
                        end
                    end
                end
                EMIT: begin
                    // x_out is held during backpressure. It advances only
                    // once the consumer has taken the minterm.
                    if (handshake && !last_vec) begin
                        x_out    <= x_out + 1'b1;
                        wait_cnt <= LAT_RELOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. Status and valid come straight from the state, so
    // m_valid cannot drop before a handshake.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        m_valid = 1'b0;
        case (state)
            WAIT: begin
                busy = 1'b1;
            end
            EMIT: begin
                busy    = 1'b1;
                m_valid = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Combinational-function instance (FN_LATENCY = 0)
    logic        start0, ready0, f0;
    logic        busy0, done0, mv0;
    logic [4:0]  x0, mi0;
    logic [5:0]  cnt0;
    logic [31:0] tt0;
    int          mode;

    // Pipelined-function instance (FN_LATENCY = 2)
    logic        start2, ready2, f2;
    logic        busy2, done2, mv2;
    logic [4:0]  x2, mi2;
    logic [5:0]  cnt2;
    logic [31:0] tt2;
    logic        d1, d2;

    truth_table_sweeper #(.N_VARS(5), .FN_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .x_out(x0), .f_in(f0), .m_valid(mv0), .m_ready(ready0),
        .m_index(mi0), .minterm_count(cnt0), .truth_table(tt0)
    );

    truth_table_sweeper #(.N_VARS(5), .FN_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .x_out(x2), .f_in(f2), .m_valid(mv2), .m_ready(ready2),
        .m_index(mi2), .minterm_count(cnt2), .truth_table(tt2)
    );

    // Function under test for dut0, selected by mode
    always_comb begin
        case (mode)
            0:       f0 = 1'b0;
            1:       f0 = x0[0] & x0[1];
            default: f0 = 1'b1;
        endcase
    end

    // Two-stage delayed function for dut2: true only for vector 17
    always @(posedge clk) begin
        d1 <= (x2 == 5'd17);
        d2 <= d1;
    end
    assign f2 = d2;

    typedef struct packed {
        logic [4:0] idx;
        logic [5:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2, ep;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Scoreboard monitors: pop and compare on every handshake
    always @(negedge clk) begin
        #1;
        if (!rst && mv0 && ready0) begin
            if (q0.size() == 0) begin
                checks++;
                $display("[TB] FAIL dut0 unexpected minterm: got index %0d, expected none", mi0);
            end else begin
                e0 = q0.pop_front();
                checkOutput("dut0 m_index", 64'(mi0), 64'(e0.idx));
                checkOutput("dut0 minterm_count", 64'(cnt0), 64'(e0.cnt));
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && mv2 && ready2) begin
            if (q2.size() == 0) begin
                checks++;
                $display("[TB] FAIL dut2 unexpected minterm: got index %0d, expected none", mi2);
            end else begin
                e2 = q2.pop_front();
                checkOutput("dut2 m_index", 64'(mi2), 64'(e2.idx));
                checkOutput("dut2 minterm_count", 64'(cnt2), 64'(e2.cnt));
            end
        end
    end

    // Pulses start for one cycle on the chosen instance; s = start cycle
    task automatic applyStimulus(input int which, output int s);
        @(negedge clk);
        if (which == 0) start0 = 1'b1;
        else            start2 = 1'b1;
        s = cyc;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    // Waits (bounded) for done, then checks latency, count, table, queue
    task automatic waitDone(input int which, input int s, input int exp_cycle,
                            input int exp_cnt, input logic [31:0] exp_tt,
                            input string name);
        int   n;
        logic d;
        n = 0;
        d = (which == 0) ? done0 : done2;
        while (!d && n < 300) begin
            @(negedge clk);
            n++;
            d = (which == 0) ? done0 : done2;
        end
        if (!d) begin
            checks++;
            $display("[TB] FAIL %s done: got no done within 300 cycles, expected cycle %0d",
                     name, exp_cycle);
        end else begin
            checkOutput({name, " done cycle"}, 64'(cyc - s), 64'(exp_cycle));
            checkOutput({name, " count"}, 64'((which == 0) ? cnt0 : cnt2), 64'(exp_cnt));
            checkOutput({name, " truth_table"}, 64'((which == 0) ? tt0 : tt2), 64'(exp_tt));
            checkOutput({name, " busy at done"}, 64'((which == 0) ? busy0 : busy2), 64'd0);
            checkOutput({name, " queue drained"},
                        64'((which == 0) ? q0.size() : q2.size()), 64'd0);
        end
    endtask

    initial begin
        int s;
        int n;

        rst    = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        ready0 = 1'b1;
        ready2 = 1'b1;
        mode   = 0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset busy", 64'(busy0), 64'd0);
        checkOutput("reset done", 64'(done0), 64'd0);
        checkOutput("reset m_valid", 64'(mv0), 64'd0);
        checkOutput("reset x_out", 64'(x0), 64'd0);
        checkOutput("reset count", 64'(cnt0), 64'd0);
        checkOutput("reset truth_table", 64'(tt0), 64'd0);
        rst = 1'b0;

        // 1: constant zero function
        mode = 0;
        applyStimulus(0, s);
        checkOutput("t1 busy", 64'(busy0), 64'd1);
        waitDone(0, s, 33, 0, 32'h0, "t1");
        @(negedge clk);
        checkOutput("t1 done pulse width", 64'(done0), 64'd0);

        // 2: f = x[0] & x[1] -> minterms 3,7,...,31
        mode = 1;
        for (int k = 0; k < 8; k++) begin
            ep.idx = 5'(3 + 4 * k);
            ep.cnt = 6'(k + 1);
            q0.push_back(ep);
        end
        applyStimulus(0, s);
        waitDone(0, s, 41, 8, 32'h8888_8888, "t2");
        @(negedge clk);
        checkOutput("t2 done pulse width", 64'(done0), 64'd0);

        // 3: constant one function -> all 32 minterms
        mode = 2;
        for (int k = 0; k < 32; k++) begin
            ep.idx = 5'(k);
            ep.cnt = 6'(k + 1);
            q0.push_back(ep);
        end
        applyStimulus(0, s);
        waitDone(0, s, 65, 32, 32'hFFFF_FFFF, "t3");
        @(negedge clk);

        // 4: latency-2 function true only at 17
        ep.idx = 5'd17;
        ep.cnt = 6'd1;
        q2.push_back(ep);
        applyStimulus(2, s);
        waitDone(2, s, 98, 1, 32'h0002_0000, "t4");
        @(negedge clk);

        // 5: backpressure on minterm 9
        mode = 2;
        for (int k = 0; k < 32; k++) begin
            ep.idx = 5'(k);
            ep.cnt = 6'(k + 1);
            q0.push_back(ep);
        end
        applyStimulus(0, s);
        n = 0;
        while (!(x0 == 5'd9 && !mv0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("[TB] FAIL t5 reach vector 9: got x_out %0d, expected 9", x0);
        end
        ready0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t5 hold m_valid", 64'(mv0), 64'd1);
            checkOutput("t5 hold m_index", 64'(mi0), 64'd9);
            checkOutput("t5 hold x_out", 64'(x0), 64'd9);
        end
        @(negedge clk);
        ready0 = 1'b1;
        waitDone(0, s, 69, 32, 32'hFFFF_FFFF, "t5");
        @(negedge clk);

        // 6: reset in the middle of EMIT at vector 12
        for (int k = 0; k < 32; k++) begin
            ep.idx = 5'(k);
            ep.cnt = 6'(k + 1);
            q0.push_back(ep);
        end
        applyStimulus(0, s);
        n = 0;
        while (!(mv0 && mi0 == 5'd12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("[TB] FAIL t6 reach minterm 12: got index %0d, expected 12", mi0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6 abort busy", 64'(busy0), 64'd0);
        checkOutput("t6 abort done", 64'(done0), 64'd0);
        checkOutput("t6 abort m_valid", 64'(mv0), 64'd0);
        checkOutput("t6 abort x_out", 64'(x0), 64'd0);
        checkOutput("t6 abort m_index", 64'(mi0), 64'd0);
        checkOutput("t6 abort count", 64'(cnt0), 64'd0);
        checkOutput("t6 abort truth_table", 64'(tt0), 64'd0);
        checkOutput("t6 unconsumed minterms", 64'(q0.size()), 64'd20);
        q0.delete();

        // Fresh sweep after the abort; start pulsed while busy is ignored
        mode = 1;
        for (int k = 0; k < 8; k++) begin
            ep.idx = 5'(3 + 4 * k);
            ep.cnt = 6'(k + 1);
            q0.push_back(ep);
        end
        applyStimulus(0, s);
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitDone(0, s, 41, 8, 32'h8888_8888, "t6");
        // A start raised during the DONE cycle must not launch a sweep
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("t6 start in DONE busy", 64'(busy0), 64'd0);
        @(negedge clk);
        checkOutput("t6 start in DONE idle", 64'(busy0), 64'd0);
        checkOutput("t6 result kept", 64'(tt0), 64'h8888_8888);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
